// File: rtl/ime_stream_if_mc_if.sv
// Input stream bundle for the multi-channel IME front end: {p, q, score} beats
// tagged with a channel ID, plus sideband and end-of-frame.
interface ime_stream_if_mc_if #(
    parameter int W_P   = 16,
    parameter int W_LOG = 16,
    parameter int CH_W  = 2
);
    logic [2*W_P+W_LOG-1:0] tdata;
    logic [7:0]             tuser;
    logic [CH_W-1:0]        tid;
    logic                   tvalid;
    logic                   tready;
    logic                   tlast;

    modport master (output tdata, tuser, tid, tvalid, tlast, input tready);
    modport slave  (input tdata, tuser, tid, tvalid, tlast, output tready);
endinterface

// File: rtl/ime_stream_if_mc.sv
// Multi-channel IME stream front end: per-channel framing and sticky poison,
// epsilon floor on p/q, FIFO buffering and a constant-time release throttle.
module ime_stream_if_mc #(
    parameter int W_P        = 16,
    parameter int W_LOG      = 16,
    parameter int N_CH       = 4,
    parameter int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1,
    parameter int FIFO_DEPTH = 4,
    parameter int W_DLY      = 14
) (
    input  logic                          clk,
    input  logic                          rst_n,
    ime_stream_if_mc_if.slave             s_axis,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [W_P-1:0]                out_prob_p,
    output logic [W_P-1:0]                out_prob_q,
    output logic [W_LOG-1:0]              out_score,
    output logic [7:0]                    out_tuser,
    output logic [CH_W-1:0]               out_ch,
    output logic                          out_last,
    output logic                          out_poison,
    input  logic [15:0]                   frame_len,
    input  logic [15:0]                   epsilon_q,
    input  logic [W_DLY-1:0]              const_time_cycles,
    input  logic                          poison_inject,
    output logic                          frame_start,
    output logic                          frame_end,
    output logic [CH_W-1:0]               frame_ch,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          bad_tid
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [W_P-1:0]   p;
        logic [W_P-1:0]   q;
        logic [W_LOG-1:0] score;
        logic [7:0]       user;
        logic [CH_W-1:0]  ch;
        logic             last;
        logic             poison;
    } entry_t;

    function automatic logic [W_P-1:0] floor_eps(input logic [W_P-1:0] v,
                                                 input logic [W_P-1:0] e);
        return (v < e) ? e : v;
    endfunction

    entry_t          mem [FIFO_DEPTH];
    entry_t          wr_entry_p0;
    entry_t          head;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     level;
    logic [W_DLY-1:0] dly;
    logic [15:0]     cnt [N_CH];
    logic [N_CH-1:0] sticky;
    logic [W_P-1:0]  eps;
    logic            full, empty, accept, pop;
    logic            tid_ok, sticky_sel, end_b;
    logic [15:0]     cnt_sel, len_eff, idx;

    if (W_P > 16) begin : g_eps_wide
        assign eps = {{(W_P-16){1'b0}}, epsilon_q};
    end else if (W_P == 16) begin : g_eps_eq
        assign eps = epsilon_q;
    end else begin : g_eps_narrow
        assign eps = epsilon_q[W_P-1:0];
    end

    assign full          = (level == (AW+1)'(FIFO_DEPTH));
    assign empty         = (level == '0);
    assign s_axis.tready = rst_n && !full;
    assign accept        = s_axis.tvalid && s_axis.tready;
    assign out_valid     = !empty && (dly == '0);
    assign pop           = out_valid && out_ready;
    assign fifo_level    = level;

    // Stage p0: channel lookup, frame-end decision and normalization of the offered beat
    always_comb begin
        tid_ok     = 1'b0;
        cnt_sel    = '0;
        sticky_sel = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            if (s_axis.tid == CH_W'(c)) begin
                tid_ok     = 1'b1;
                cnt_sel    = cnt[c];
                sticky_sel = sticky[c];
            end
        end
        len_eff = (frame_len == '0) ? 16'd1 : frame_len;
        idx     = cnt_sel + 16'd1;
        end_b   = s_axis.tlast || (idx >= len_eff);

        wr_entry_p0.p      = floor_eps(s_axis.tdata[2*W_P+W_LOG-1 -: W_P], eps);
        wr_entry_p0.q      = floor_eps(s_axis.tdata[W_P+W_LOG-1 -: W_P], eps);
        wr_entry_p0.score  = s_axis.tdata[W_LOG-1:0];
        wr_entry_p0.user   = s_axis.tuser;
        wr_entry_p0.ch     = s_axis.tid;
        wr_entry_p0.last   = end_b || !tid_ok;
        wr_entry_p0.poison = poison_inject || sticky_sel || !tid_ok;
    end

    // Bad channel IDs leave all per-channel state untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) cnt[c] <= '0;
            sticky <= '0;
        end else if (accept && tid_ok) begin
            for (int c = 0; c < N_CH; c++) begin
                if (s_axis.tid == CH_W'(c)) begin
                    cnt[c] <= end_b ? '0 : idx;
                    if (end_b)
                        sticky[c] <= 1'b0;
                    else if (poison_inject)
                        sticky[c] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            frame_ch    <= '0;
            bad_tid     <= 1'b0;
        end else begin
            frame_start <= accept && tid_ok && (cnt_sel == '0);
            frame_end   <= accept && tid_ok && end_b;
            frame_ch    <= (accept && tid_ok) ? s_axis.tid : '0;
            bad_tid     <= accept && !tid_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= wr_entry_p0;
    end

    // Stage p1: FIFO bookkeeping; dly reloads whenever a fresh entry reaches the head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            dly    <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            if (accept && !pop)
                level <= level + 1'b1;
            else if (pop && !accept)
                level <= level - 1'b1;

            if (accept && empty)
                dly <= const_time_cycles;
            else if (pop && (level > (AW+1)'(1) || accept))
                dly <= const_time_cycles;
            else if (dly != '0)
                dly <= dly - 1'b1;
        end
    end

    assign head       = empty ? '0 : mem[rd_ptr];
    assign out_prob_p = head.p;
    assign out_prob_q = head.q;
    assign out_score  = head.score;
    assign out_tuser  = head.user;
    assign out_ch     = head.ch;
    assign out_last   = head.last;
    assign out_poison = head.poison;
endmodule

// File: tb/tb_ime_stream_if_mc.sv
// Self-checking bench for ime_stream_if_mc: directed scenarios plus a random
// phase, all checked against a queue-based reference model.
module tb_ime_stream_if_mc;
    localparam int W_P = 16, W_LOG = 16, N_CH = 4, CH_W = 3, DEPTH = 4, W_DLY = 14;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ime_stream_if_mc_if #(.W_P(W_P), .W_LOG(W_LOG), .CH_W(CH_W)) s_axis ();

    logic             out_valid, out_ready;
    logic [15:0]      out_prob_p, out_prob_q, out_score;
    logic [7:0]       out_tuser;
    logic [CH_W-1:0]  out_ch, frame_ch;
    logic             out_last, out_poison, frame_start, frame_end, bad_tid;
    logic [15:0]      frame_len, epsilon_q;
    logic [W_DLY-1:0] ctc;
    logic             poison_inject;
    logic [2:0]       fifo_level;

    ime_stream_if_mc #(.W_P(W_P), .W_LOG(W_LOG), .N_CH(N_CH), .CH_W(CH_W),
                       .FIFO_DEPTH(DEPTH), .W_DLY(W_DLY)) dut (
        .clk(clk), .rst_n(rst_n), .s_axis(s_axis),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_prob_p(out_prob_p), .out_prob_q(out_prob_q), .out_score(out_score),
        .out_tuser(out_tuser), .out_ch(out_ch), .out_last(out_last), .out_poison(out_poison),
        .frame_len(frame_len), .epsilon_q(epsilon_q), .const_time_cycles(ctc),
        .poison_inject(poison_inject), .frame_start(frame_start), .frame_end(frame_end),
        .frame_ch(frame_ch), .fifo_level(fifo_level), .bad_tid(bad_tid)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: expected FIFO contents, per-channel frame position and poison
    typedef struct packed {
        logic [15:0]     p;
        logic [15:0]     q;
        logic [15:0]     s;
        logic [7:0]      u;
        logic [CH_W-1:0] ch;
        logic            last;
        logic            poison;
    } beat_t;

    beat_t mq[$];
    beat_t mb;
    int    mcnt[N_CH];
    bit    msticky[N_CH];
    int    mdly, msz, mtid, mlen;
    bit    macc, mpop, mend;
    bit    ex_fs, ex_fe, ex_bad;
    int    ex_ch;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ctrl", {out_valid, s_axis.tready, fifo_level, frame_start, frame_end,
                             frame_ch, bad_tid}, '0);
            chk("rst_data", {out_prob_p, out_prob_q, out_score, out_tuser, out_ch,
                             out_last, out_poison}, '0);
            mq.delete();
            for (int c = 0; c < N_CH; c++) begin
                mcnt[c] = 0;
                msticky[c] = 0;
            end
            mdly = 0;
            ex_fs = 0; ex_fe = 0; ex_bad = 0; ex_ch = 0;
        end else begin
            msz = mq.size();
            chk("fifo_level", fifo_level, msz);
            chk("tready", s_axis.tready, msz < DEPTH);
            chk("out_valid", out_valid, (msz > 0) && (mdly == 0));
            if (msz > 0 && mdly == 0)
                chk("head", {out_prob_p, out_prob_q, out_score, out_tuser, out_ch,
                             out_last, out_poison}, mq[0]);
            chk("pulses", {frame_start, frame_end, frame_ch, bad_tid},
                {ex_fs, ex_fe, CH_W'(ex_ch), ex_bad});

            macc = s_axis.tvalid && (msz < DEPTH);
            mpop = (msz > 0) && (mdly == 0) && out_ready;
            ex_fs = 0; ex_fe = 0; ex_bad = 0; ex_ch = 0;
            if (macc) begin
                mtid = int'(s_axis.tid);
                mb.p = (s_axis.tdata[47:32] < epsilon_q) ? epsilon_q : s_axis.tdata[47:32];
                mb.q = (s_axis.tdata[31:16] < epsilon_q) ? epsilon_q : s_axis.tdata[31:16];
                mb.s = s_axis.tdata[15:0];
                mb.u = s_axis.tuser;
                mb.ch = s_axis.tid;
                if (mtid >= N_CH) begin
                    mb.last = 1; mb.poison = 1; ex_bad = 1;
                end else begin
                    mlen = (frame_len == 0) ? 1 : int'(frame_len);
                    mend = s_axis.tlast || (mcnt[mtid] + 1 >= mlen);
                    ex_fs = (mcnt[mtid] == 0);
                    ex_fe = mend;
                    ex_ch = mtid;
                    mb.last = mend;
                    mb.poison = poison_inject || msticky[mtid];
                    mcnt[mtid] = mend ? 0 : mcnt[mtid] + 1;
                    if (mend) msticky[mtid] = 0;
                    else if (poison_inject) msticky[mtid] = 1;
                end
            end
            if (mpop) void'(mq.pop_front());
            if (macc) mq.push_back(mb);
            if (macc && msz == 0) mdly = int'(ctc);
            else if (mpop && mq.size() > 0) mdly = int'(ctc);
            else if (mdly > 0) mdly--;
        end
    end

    int          cyc = 0;
    int          pop_cyc[$];
    logic [15:0] pop_sc[$];
    always @(negedge clk) begin
        cyc++;
        if (rst_n && out_valid && out_ready) begin
            pop_cyc.push_back(cyc);
            pop_sc.push_back(out_score);
        end
    end

    bit rnd_ready = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int tid, input logic [15:0] p, input logic [15:0] q,
                         input logic [15:0] s, input logic [7:0] u, input bit last, input bit pinj);
        s_axis.tvalid = 1'b1;
        s_axis.tid    = CH_W'(tid);
        s_axis.tdata  = {p, q, s};
        s_axis.tuser  = u;
        s_axis.tlast  = last;
        poison_inject = pinj;
    endtask

    task automatic wait_accept();
        bit ok;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = s_axis.tready;
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        poison_inject = 1'b0;
        n_vec++;
        assert (ok) else begin
            n_err++;
            $error("FAIL accept_timeout: observed tready 0 expected 1 within 200 cycles");
        end
    endtask

    task automatic send(input int tid, input logic [15:0] p, input logic [15:0] q,
                        input logic [15:0] s, input bit last, input bit pinj);
        drive(tid, p, q, s, s[7:0] ^ 8'h5A, last, pinj);
        wait_accept();
    endtask

    task automatic wait_drain();
        bit done;
        done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (fifo_level == 0) done = 1;
            else tick();
        end
        n_vec++;
        assert (done) else begin
            n_err++;
            $error("FAIL drain_timeout: observed fifo_level %0d expected 0", fifo_level);
        end
    endtask

    initial begin
        int tid;
        logic [15:0] p, q;
        s_axis.tvalid = 0; s_axis.tdata = '0; s_axis.tuser = '0; s_axis.tid = '0; s_axis.tlast = 0;
        out_ready = 1; frame_len = 16'd3; epsilon_q = 0; ctc = 0; poison_inject = 0;

        // Reset state
        repeat (3) tick();
        chk("rst_tready", s_axis.tready, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_tready", s_axis.tready, 1'b1);
        chk("post_rst_valid", out_valid, 1'b0);

        // Single-channel frame of 3, zero throttle
        send(0, 16'h1000, 16'h2000, 16'h0001, 0, 0);
        chk("t1_b1_valid", out_valid, 1'b1);
        chk("t1_b1_pulse", {frame_start, frame_end, frame_ch, out_last}, {1'b1, 1'b0, 3'd0, 1'b0});
        send(0, 16'h1001, 16'h2001, 16'h0002, 0, 0);
        chk("t1_b2_pulse", {frame_start, frame_end, out_last}, {1'b0, 1'b0, 1'b0});
        send(0, 16'h1002, 16'h2002, 16'h0003, 0, 0);
        chk("t1_b3_pulse", {frame_start, frame_end, out_last, out_valid}, {1'b0, 1'b1, 1'b1, 1'b1});

        // Interleaved channels, frame of 2
        frame_len = 16'd2;
        send(0, 16'h0100, 16'h0100, 16'h0010, 0, 0);
        chk("t2_b1", {frame_start, frame_end, frame_ch, out_last}, {1'b1, 1'b0, 3'd0, 1'b0});
        send(1, 16'h0100, 16'h0100, 16'h0011, 0, 0);
        chk("t2_b2", {frame_start, frame_end, frame_ch, out_last}, {1'b1, 1'b0, 3'd1, 1'b0});
        send(0, 16'h0100, 16'h0100, 16'h0012, 0, 0);
        chk("t2_b3", {frame_start, frame_end, frame_ch, out_last}, {1'b0, 1'b1, 3'd0, 1'b1});
        send(1, 16'h0100, 16'h0100, 16'h0013, 0, 0);
        chk("t2_b4", {frame_start, frame_end, frame_ch, out_last}, {1'b0, 1'b1, 3'd1, 1'b1});

        // Epsilon floor
        epsilon_q = 16'h0010;
        send(0, 16'h0005, 16'h0100, 16'hBEEF, 1, 0);
        chk("t3_floor_p", out_prob_p, 16'h0010);
        chk("t3_floor_q", out_prob_q, 16'h0100);
        chk("t3_score", out_score, 16'hBEEF);
        epsilon_q = 16'h0000;
        send(0, 16'h0005, 16'h0100, 16'h1234, 1, 0);
        chk("t3_pass_p", out_prob_p, 16'h0005);

        // Sticky poison on ch2, ch3 unaffected
        frame_len = 16'd4;
        send(2, 16'h0200, 16'h0200, 16'h0020, 0, 1);
        chk("t4_c2b1", out_poison, 1'b1);
        send(3, 16'h0300, 16'h0300, 16'h0030, 0, 0);
        chk("t4_c3b1", out_poison, 1'b0);
        send(2, 16'h0200, 16'h0200, 16'h0021, 0, 0);
        chk("t4_c2b2", out_poison, 1'b1);
        send(3, 16'h0300, 16'h0300, 16'h0031, 0, 0);
        chk("t4_c3b2", out_poison, 1'b0);
        send(2, 16'h0200, 16'h0200, 16'h0022, 0, 0);
        chk("t4_c2b3", out_poison, 1'b1);
        send(2, 16'h0200, 16'h0200, 16'h0023, 0, 0);
        chk("t4_c2b4", {out_poison, out_last}, {1'b1, 1'b1});
        send(2, 16'h0200, 16'h0200, 16'h0024, 0, 0);
        chk("t4_c2_next", {out_poison, frame_start}, {1'b0, 1'b1});

        // Backpressure to full, then throttled release
        tick();
        wait_drain();
        frame_len = 16'd3;
        out_ready = 0;
        for (int i = 0; i < 4; i++) send(0, 16'h0400, 16'h0400, 16'(i), 0, 0);
        drive(0, 16'h0400, 16'h0400, 16'd4, 8'h00, 0, 0);
        repeat (3) tick();
        chk("t5_tready", s_axis.tready, 1'b0);
        chk("t5_level", fifo_level, 3'd4);
        pop_cyc.delete();
        pop_sc.delete();
        ctc = 14'd3;
        out_ready = 1;
        wait_accept();
        send(0, 16'h0400, 16'h0400, 16'd5, 0, 0);
        wait_drain();
        tick();
        chk("t5_pops", pop_cyc.size(), 6);
        for (int i = 1; i < pop_cyc.size(); i++) chk("t5_spacing", pop_cyc[i] - pop_cyc[i-1], 4);
        for (int i = 0; i < pop_sc.size(); i++) chk("t5_order", pop_sc[i], i);

        // Bad tid, then reset mid-frame
        ctc = 0;
        frame_len = 16'd4;
        send(5, 16'h0500, 16'h0500, 16'h0050, 0, 0);
        chk("t6_bad", {out_poison, out_last, bad_tid, frame_start, frame_end},
            {1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        send(3, 16'h0300, 16'h0300, 16'h0032, 0, 0);
        chk("t6_c3_unchanged", {frame_start, frame_end, out_poison}, {1'b0, 1'b0, 1'b0});
        send(1, 16'h0100, 16'h0100, 16'h0014, 0, 0);
        chk("t6_c1_start", frame_start, 1'b1);
        send(1, 16'h0100, 16'h0100, 16'h0015, 0, 1);
        rst_n = 1'b0;
        tick();
        chk("t6_rst_valid", {out_valid, s_axis.tready, fifo_level}, '0);
        tick();
        rst_n = 1'b1;
        tick();
        send(1, 16'h0100, 16'h0100, 16'h0016, 0, 0);
        chk("t6_after_rst", {frame_start, out_poison}, {1'b1, 1'b0});

        // Random phase
        rnd_ready = 1;
        for (int n = 0; n < 400; n++) begin
            tid = $urandom_range(0, 5);
            p = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 63)) : 16'($urandom);
            q = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 63)) : 16'($urandom);
            epsilon_q = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(0, 48));
            frame_len = 16'($urandom_range(0, 5));
            ctc = 14'($urandom_range(0, 2));
            drive(tid, p, q, 16'($urandom), 8'($urandom), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 9) == 0);
            wait_accept();
            if ($urandom_range(0, 3) == 0) tick();
        end
        rnd_ready = 0;
        out_ready = 1;
        wait_drain();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
